mem_serial_lsu: RTL and testbench
=================================

MEM_SERIAL_LSU -- requirements
Module: mem_serial_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width in bits; legal values are 8, 16, 32 and 64; derived NBYTES = DATA_W/8.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning a request is offered.
REQ-006 SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-007 SHALL have request ports req_write (in, 1), req_addr (in, ADDR_W), req_wdata (in, DATA_W), req_size (in, 2) and req_signed (in, 1); req_size gives log2 of the byte count.
REQ-008 SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-009 SHALL have port resp_rdata, output, DATA_W, meaning the extended load data.
REQ-010 SHALL have byte-memory ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, 8), mem_rdata (in, 8) and mem_ready (in, 1).

Function
REQ-011 SHALL accept a request on a rising edge where req_valid && req_ready, and latch all req_* fields.
REQ-012 SHALL implement states IDLE, XFER and DONE:
- IDLE to XFER on acceptance.
- XFER to DONE after the last byte completes.
- DONE to IDLE unconditionally.
REQ-013 SHALL drive req_ready = 1 only in IDLE and only while reset is low.
REQ-014 SHALL compute byte count N = 2^req_size, saturated to NBYTES when 2^req_size > NBYTES.
REQ-015 SHALL, in XFER, assert mem_en and drive mem_addr = base + i (modulo 2^ADDR_W), where i counts 0..N-1.
REQ-016 SHALL treat a byte as complete on a rising edge where mem_en && mem_ready; i SHALL increment only on completion.
REQ-017 SHALL hold mem_addr, mem_we and mem_wdata stable while mem_ready is low, for any number of wait cycles.
REQ-018 SHALL, on stores, drive mem_we = 1 and mem_wdata = wdata[8i+7:8i] (little-endian).
REQ-019 SHALL, on loads, drive mem_we = 0 and capture mem_rdata into byte i of the load buffer on completion.
REQ-020 SHALL, in DONE, assert resp_valid for exactly one cycle.
REQ-021 SHALL make resp_rdata equal to the low 8N bits of the buffer, zero-extended, or sign-extended from bit 8N-1 when req_signed; for stores resp_rdata SHALL be 0.
REQ-022 SHALL have load latency N+2 edges from acceptance to the first rising edge after resp_valid goes low, with mem_ready tied high; each wait cycle adds one edge.
REQ-023 SHALL hold resp_rdata until the next acceptance.
REQ-024 SHALL drive mem_en = mem_we = 0 outside XFER.
REQ-025 SHALL ignore req_valid outside IDLE; a request is never dropped or duplicated.
REQ-026 SHALL let an address that wraps past 2^ADDR_W-1 continue at 0 with no error.

Reset
REQ-027 SHALL, while reset is high, force:
- state = IDLE, i = 0;
- req_ready = 0, resp_valid = 0, mem_en = 0, mem_we = 0;
- mem_addr = 0, mem_wdata = 0, resp_rdata = 0;
- load buffer = 0.
REQ-028 SHALL, when reset is asserted mid-transfer, deassert mem_en immediately (asynchronously) and never issue resp_valid for the aborted request.
REQ-029 SHALL accept a request on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place in shared package lsu_pkg:
- the state enum (IDLE, XFER, DONE);
- req_size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2, SZ_DOUBLE = 3.
REQ-031 SHALL instantiate exactly one sub-module, lsu_extend: a combinational zero/sign extender taking buffer, N and signed.

Verification
REQ-032 Byte load: DATA_W = 32, mem_ready = 1, addr 0x10, size 0, signed = 1, mem[0x10] = 0x80 -> resp_valid 3 edges after acceptance, resp_rdata = 0xFFFFFF80.
REQ-033 Word store: addr 0x20, wdata 0xA1B2C3D4, size 2 -> mem_addr 0x20..0x23 with mem_wdata D4, C3, B2, A1; one resp_valid; resp_rdata = 0.
REQ-034 Wait states: half load, unsigned, mem[0x40..0x41] = 34, 12, mem_ready low 3 cycles before each byte -> address held, resp_rdata = 0x00001234, 2 + 2 + 6 edges.
REQ-035 Wrap and saturation: ADDR_W = 8, addr 0xFF, size 3 with DATA_W = 32 -> 4 bytes at addresses FF, 00, 01, 02.
REQ-036 Reset abort: reset after byte 1 of a word load -> mem_en low in the same cycle, no resp_valid, next request completes normally.
REQ-037 Back-to-back: req_valid held high with two requests -> second accepted only in IDLE after DONE; exactly two resp_valid pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the serial byte-wide load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  // 2^size bytes, clipped to the number of bytes a data word can hold.
  function automatic logic [3:0] byte_count(input logic [1:0] size, input int nbytes);
    logic [3:0] n;
    n = 4'd1 << size;
    if (int'(n) > nbytes) n = 4'(nbytes);
    return n;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Zero/sign extension of the low nbytes bytes of the load buffer to a full word.
module lsu_extend #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] buffer,
  input  logic [3:0]        nbytes,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);

  localparam int NBYTES = DATA_W / 8;

  logic fill;
  int   top;

  always_comb begin
    fill = 1'b0;
    data = '0;
    top  = 8 * int'(nbytes) - 1;
    if (is_signed && nbytes != 4'd0 && top < DATA_W) fill = buffer[top];
    for (int k = 0; k < NBYTES; k++) begin
      data[8*k +: 8] = (k < int'(nbytes)) ? buffer[8*k +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/mem_serial_lsu.sv
// Load/store unit that moves 1..NBYTES bytes one at a time over a byte-wide memory port.
module mem_serial_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output lsu_state_t        fsm_state
);

  localparam int NBYTES = DATA_W / 8;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a memory byte transfers on a rising edge where mem_en && mem_ready, and the
  // byte address/data stay put until that edge.

  lsu_state_t        state, state_nxt;
  logic [3:0]        idx, nbytes;
  logic [ADDR_W-1:0] base;
  logic              write_q, signed_q;
  logic [DATA_W-1:0] wdata_q, load_buf;
  logic              accept, byte_done, last_byte;

  assign accept    = req_valid && req_ready;
  assign byte_done = mem_en && mem_ready;
  assign last_byte = byte_done && (idx == nbytes - 4'd1);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) state_nxt = XFER;
      end
      XFER: begin
        mem_en = 1'b1;
        mem_we = write_q;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and store byte are pure functions of held registers, so they cannot move during waits.
  assign mem_addr  = mem_en ? (base + ADDR_W'(idx)) : '0;
  assign mem_wdata = mem_we ? wdata_q[8*int'(idx) +: 8] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base     <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      nbytes   <= '0;
      idx      <= '0;
      load_buf <= '0;
    end else if (accept) begin
      base     <= req_addr;
      write_q  <= req_write;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
      nbytes   <= byte_count(req_size, NBYTES);
      idx      <= '0;
      load_buf <= '0;
    end else if (byte_done) begin
      idx <= last_byte ? 4'd0 : idx + 4'd1;
      if (!write_q) load_buf[8*int'(idx) +: 8] <= mem_rdata;
    end
  end

  // Stores never write load_buf, so their response reads back as zero.
  lsu_extend #(.DATA_W(DATA_W)) u_extend (
    .buffer    (load_buf),
    .nbytes    (nbytes),
    .is_signed (signed_q),
    .data      (resp_rdata)
  );

endmodule

// File: tb/tb_mem_serial_lsu.sv
// Directed bench for mem_serial_lsu with a transaction-level reference model and byte memory.
module tb_mem_serial_lsu;
  import lsu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_size = 2'd0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_we, mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  lsu_state_t    fsm_state;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  mem_serial_lsu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int wait_n = 0, wcnt = 0;
  int accept_cnt = 0, resp_cnt = 0, bytes_done = 0;
  int accept_edge = 0, resp_edge = 0;
  logic [DW-1:0] last_resp;

  logic [AW-1:0] ea_q[$];
  logic          ewe_q[$];
  logic [7:0]    ew_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [7:0]    wd_log[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Expected byte transactions and response for one request, from the memory contents.
  task automatic model_push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    logic [AW-1:0] ai;
    n = 1 << sz;
    if (n > NB) n = NB;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = a + AW'(i);
      ea_q.push_back(ai);
      ewe_q.push_back(w);
      ew_q.push_back(w ? wd[8*i +: 8] : 8'h00);
      v = v | (64'(mem[ai]) << (8 * i));
    end
    if (w) v = 0;
    else if (sg && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    exp_q.push_back(v[DW-1:0]);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      ea_q.delete(); ewe_q.delete(); ew_q.delete(); exp_q.delete();
      wcnt = 0;
      mem_ready = (wait_n == 0);
    end else begin
      if (mem_en) begin
        if (wcnt < wait_n) begin mem_ready = 1'b0; wcnt++; end
        else begin mem_ready = 1'b1; wcnt = 0; end
      end else begin
        mem_ready = (wait_n == 0);
        wcnt = 0;
      end
      if (mem_en) begin
        if (ea_q.size() == 0) check("byte_unexpected", 1, 0);
        else begin
          check("mem_addr", mem_addr, ea_q[0]);
          check("mem_we", mem_we, ewe_q[0]);
          check("mem_wdata", mem_wdata, ew_q[0]);
          if (mem_ready) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            addr_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
            void'(ea_q.pop_front()); void'(ewe_q.pop_front()); void'(ew_q.pop_front());
            bytes_done++;
          end
        end
      end else begin
        check("idle_mem_we", mem_we, 0);
      end
      if (resp_valid) begin
        resp_cnt++;
        resp_edge = cyc;
        last_resp = resp_rdata;
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          check("resp_rdata", resp_rdata, exp_q[0]);
          check("resp_bytes_left", ea_q.size(), 0);
          void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        accept_edge = cyc + 1;
        accept_cnt++;
        model_push(req_write, req_addr, req_wdata, req_size, req_signed);
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [1:0] sz, input logic sg, input bit keep, output int tries);
    int start;
    start = accept_cnt;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    tries = 0;
    while (accept_cnt == start && tries < 200) begin
      @(negedge clk); #1;
      tries++;
    end
    if (accept_cnt == start) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int target);
    int k;
    k = 0;
    while (resp_cnt < target && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    if (resp_cnt < target) check("resp_timeout", resp_cnt, target);
  endtask

  int t, rc, cyc_d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'h80;
    mem[8'h40] = 8'h34; mem[8'h41] = 8'h12;
    mem[8'h50] = 8'h00; mem[8'h51] = 8'hF0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_state", fsm_state, IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    // Signed byte load
    rc = resp_cnt;
    issue(1'b0, 8'h10, '0, SZ_BYTE, 1'b1, 1'b0, t);
    wait_resp(rc + 1);
    check("byte_load_data", last_resp, 32'hFFFFFF80);
    check("byte_load_latency", resp_edge - accept_edge + 2, 3);

    // Word store
    addr_log.delete(); wd_log.delete();
    rc = resp_cnt;
    issue(1'b1, 8'h20, 32'hA1B2C3D4, SZ_WORD, 1'b0, 1'b0, t);
    wait_resp(rc + 1);
    check("store_addr0", addr_log[0], 8'h20);
    check("store_addr3", addr_log[3], 8'h23);
    check("store_wd0", wd_log[0], 8'hD4);
    check("store_wd1", wd_log[1], 8'hC3);
    check("store_wd2", wd_log[2], 8'hB2);
    check("store_wd3", wd_log[3], 8'hA1);
    check("store_resp", last_resp, 0);
    check("store_latency", resp_edge - accept_edge + 2, 6);

    // Half load with three wait cycles per byte
    wait_n = 3;
    rc = resp_cnt;
    issue(1'b0, 8'h40, '0, SZ_HALF, 1'b0, 1'b0, t);
    wait_resp(rc + 1);
    check("wait_half_data", last_resp, 32'h00001234);
    check("wait_half_latency", resp_edge - accept_edge + 2, 10);
    wait_n = 0;
    @(posedge clk); #1;

    // Signed half load, negative
    rc = resp_cnt;
    issue(1'b0, 8'h50, '0, SZ_HALF, 1'b1, 1'b0, t);
    wait_resp(rc + 1);
    check("signed_half_data", last_resp, 32'hFFFFF000);

    // Address wrap with double size saturated to a word
    addr_log.delete();
    rc = resp_cnt;
    issue(1'b0, 8'hFF, '0, SZ_DOUBLE, 1'b0, 1'b0, t);
    wait_resp(rc + 1);
    check("wrap_count", addr_log.size(), 4);
    check("wrap_a0", addr_log[0], 8'hFF);
    check("wrap_a1", addr_log[1], 8'h00);
    check("wrap_a3", addr_log[3], 8'h02);
    check("wrap_data", last_resp, {mem[8'h02], mem[8'h01], mem[8'h00], mem[8'hFF]});

    // Reset during a word load, after its first byte
    rc = resp_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30; req_size = SZ_WORD; req_signed = 1'b0;
    t = bytes_done;
    for (int k = 0; k < 50 && bytes_done == t; k++) begin @(negedge clk); #1; end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_mid_xfer", mem_en, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_mem_en", mem_en, 0);
    check("abort_req_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    cyc_d = cyc;
    issue(1'b0, 8'h40, '0, SZ_HALF, 1'b0, 1'b0, t);
    check("post_reset_first_edge", accept_edge, cyc_d + 1);
    wait_resp(rc + 1);
    check("abort_resp_count", resp_cnt, rc + 1);
    check("post_reset_data", last_resp, 32'h00001234);

    // Back-to-back with req_valid held high
    rc = resp_cnt;
    issue(1'b0, 8'h10, '0, SZ_BYTE, 1'b0, 1'b1, t);
    t = resp_edge;
    issue(1'b0, 8'h40, '0, SZ_HALF, 1'b1, 1'b0, t);
    check("b2b_accept_gap", accept_edge - resp_edge, 2);
    wait_resp(rc + 2);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_resp_count", resp_cnt, rc + 2);
    check("b2b_data", last_resp, 32'h00001234);

    check("model_bytes_drained", ea_q.size(), 0);
    check("model_resp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
